// File: rtl/alu_pkg.sv
// Shared types for the EX-stage ALU with iterative multiply/divide.
// Opcode map, multiply/divide FSM states and opcode classification.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_SLL     = 5'b00000,
        OP_SLL_ALT = 5'b00001,
        OP_SRL     = 5'b00010,
        OP_SRA     = 5'b00011,
        OP_SLT     = 5'b00110,
        OP_SLTU    = 5'b00111,
        OP_AND     = 5'b01000,
        OP_OR      = 5'b01001,
        OP_XOR     = 5'b01010,
        OP_NOR     = 5'b01011,
        OP_ADD     = 5'b01100,
        OP_SUB     = 5'b01110,
        OP_PASS    = 5'b01111,
        OP_MULT    = 5'b10000,
        OP_MULTU   = 5'b10001,
        OP_DIV     = 5'b10010,
        OP_DIVU    = 5'b10011,
        OP_MFHI    = 5'b10100,
        OP_MFLO    = 5'b10101,
        OP_MTHI    = 5'b10110,
        OP_MTLO    = 5'b10111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_t;

    function automatic logic is_muldiv(input logic [4:0] op);
        return op[4:2] == 3'b100;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
//   state | meaning
//   IDLE  | waiting for start; MTHI/MTLO writes accepted
//   MUL   | shift-add on operand magnitudes, one bit per cycle
//   DIV   | restoring division on magnitudes, one quotient bit per cycle
//   FIX   | apply signs, write {HI,LO}, pulse done
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             kill,
    input  logic             start,
    input  logic [1:0]       op_lo,
    input  logic [WIDTH-1:0] v1,
    input  logic [WIDTH-1:0] v2,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    md_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   acc_q, ql_q, mag_b_q;
    logic               neg_res_q, neg_rem_q, dz_q, is_div_q;

    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // op_lo[0] selects the unsigned variant, op_lo[1] selects divide
    assign sa    = !op_lo[0] && v1[WIDTH-1];
    assign sb    = !op_lo[0] && v2[WIDTH-1];
    assign mag_a = sa ? -v1 : v1;
    assign mag_b = sb ? -v2 : v2;

    assign mul_sum   = {1'b0, acc_q} + (ql_q[0] ? {1'b0, mag_b_q} : '0);
    assign div_trial = {acc_q, ql_q[WIDTH-1]} - {1'b0, mag_b_q};

    assign prod     = {acc_q, ql_q};
    assign prod_fix = neg_res_q ? -prod : prod;
    // Divide by zero leaves |v1| in the remainder; re-applying the dividend sign restores v1 itself.
    assign quo_fix  = dz_q ? '1 : (neg_res_q ? -ql_q : ql_q);
    assign rem_fix  = neg_rem_q ? -acc_q : acc_q;

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            IDLE: if (start && !kill) state_d = op_lo[1] ? DIV : MUL;
            MUL, DIV: begin
                if (kill)                     state_d = IDLE;
                else if (cnt_q == CNT_W'(1))  state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done    = !kill;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            ql_q      <= '0;
            mag_b_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            is_div_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start && !kill) begin
                    cnt_q     <= CNT_W'(WIDTH);
                    acc_q     <= '0;
                    ql_q      <= mag_a;
                    mag_b_q   <= mag_b;
                    neg_res_q <= sa ^ sb;
                    neg_rem_q <= sa;
                    dz_q      <= op_lo[1] && (v2 == '0);
                    is_div_q  <= op_lo[1];
                end
                MUL: begin
                    if (kill) cnt_q <= '0;
                    else begin
                        {acc_q, ql_q} <= {mul_sum, ql_q[WIDTH-1:1]};
                        cnt_q         <= cnt_q - 1'b1;
                    end
                end
                DIV: begin
                    if (kill) cnt_q <= '0;
                    else begin
                        if (!div_trial[WIDTH]) begin
                            acc_q <= div_trial[WIDTH-1:0];
                            ql_q  <= {ql_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_q <= {acc_q[WIDTH-2:0], ql_q[WIDTH-1]};
                            ql_q  <= {ql_q[WIDTH-2:0], 1'b0};
                        end
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (state_q == FIX && !kill) begin
            if (is_div_q) begin
                hi <= rem_fix;
                lo <= quo_fix;
            end else begin
                {hi, lo} <= prod_fix;
            end
        end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage ALU: registered simple ops with valid/ready handshake, plus
// HI/LO moves and the iterative multiply/divide unit.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             kill,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [WIDTH-1:0] in_v1,
    input  logic [WIDTH-1:0] in_v2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_wb,
    output logic             busy
);

    localparam int SHAMT_W = $clog2(WIDTH);

    logic               accept, md_start, md_done;
    logic [WIDTH-1:0]   hi, lo, res;
    logic               res_wb;
    logic [SHAMT_W-1:0] shamt;

    assign in_ready = !busy && !kill && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign md_start = accept && is_muldiv(in_op);
    assign shamt    = in_v1[SHAMT_W-1:0];

    muldiv_iter #(.WIDTH(WIDTH)) u_md (
        .clk    (clk),
        .resetn (resetn),
        .kill   (kill),
        .start  (md_start),
        .op_lo  (in_op[1:0]),
        .v1     (in_v1),
        .v2     (in_v2),
        .mthi   (accept && in_op == OP_MTHI),
        .mtlo   (accept && in_op == OP_MTLO),
        .wdata  (in_v1),
        .done   (md_done),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always_comb begin
        res    = '0;
        res_wb = 1'b1;
        case (in_op)
            OP_SLL, OP_SLL_ALT: res = in_v2 << shamt;
            OP_SRL:  res = in_v2 >> shamt;
            OP_SRA:  res = $signed(in_v2) >>> shamt;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(in_v1) < $signed(in_v2)};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, in_v1 < in_v2};
            OP_AND:  res = in_v1 & in_v2;
            OP_OR:   res = in_v1 | in_v2;
            OP_XOR:  res = in_v1 ^ in_v2;
            OP_NOR:  res = ~(in_v1 | in_v2);
            OP_ADD:  res = in_v1 + in_v2;
            OP_SUB:  res = in_v1 - in_v2;
            OP_PASS: res = in_v2;
            OP_MFHI: res = hi;
            OP_MFLO: res = lo;
            // unused simple codes write back zero; MTHI/MTLO and 11xxx do not write back
            default: res_wb = !in_op[4];
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_wb    <= 1'b0;
        end else if (kill) begin
            out_valid <= 1'b0;
        end else if (accept && !is_muldiv(in_op)) begin
            out_valid <= 1'b1;
            out_data  <= res;
            out_wb    <= res_wb;
        end else if (md_done) begin
            out_valid <= 1'b1;
            out_data  <= '0;
            out_wb    <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: directed corner cases then randomized ops
// against a plain-arithmetic model of the ALU and HI/LO registers.
module tb_alu_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0, resetn = 1'b0, kill = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [4:0]   in_op = '0;
    logic [W-1:0] in_v1 = '0, in_v2 = '0;
    logic         in_ready, out_valid, out_wb, busy;
    logic [W-1:0] out_data;

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .resetn(resetn), .kill(kill), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_v1(in_v1), .in_v2(in_v2), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_wb(out_wb), .busy(busy)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         wb;
    } beat_t;

    beat_t        expq[$];
    logic [W-1:0] m_hi = '0, m_lo = '0;
    int           nchecks = 0, nerrors = 0;
    int           cyc = 0, acc_cyc = 0;
    bit           rand_ready = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the architectural effect of one accepted op.
    task automatic model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output beat_t r);
        int unsigned       sh;
        longint            sp, sq, sr;
        longint unsigned   up;
        sh = a % W;
        r.data = '0;
        r.wb   = 1'b1;
        case (op)
            5'd0, 5'd1: r.data = b << sh;
            5'd2:  r.data = b >> sh;
            5'd3:  r.data = $signed(b) >>> sh;
            5'd6:  r.data = ($signed(a) < $signed(b)) ? 1 : 0;
            5'd7:  r.data = (a < b) ? 1 : 0;
            5'd8:  r.data = a & b;
            5'd9:  r.data = a | b;
            5'd10: r.data = a ^ b;
            5'd11: r.data = ~(a | b);
            5'd12: r.data = a + b;
            5'd14: r.data = a - b;
            5'd15: r.data = b;
            5'd16: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                m_hi = sp[63:32]; m_lo = sp[31:0]; r.wb = 1'b0;
            end
            5'd17: begin
                up = {32'b0, a} * {32'b0, b};
                m_hi = up[63:32]; m_lo = up[31:0]; r.wb = 1'b0;
            end
            5'd18: begin
                r.wb = 1'b0;
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    m_lo = sq[31:0]; m_hi = sr[31:0];
                end
            end
            5'd19: begin
                r.wb = 1'b0;
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
            5'd20: r.data = m_hi;
            5'd21: r.data = m_lo;
            5'd22: begin m_hi = a; r.wb = 1'b0; end
            5'd23: begin m_lo = a; r.wb = 1'b0; end
            default: r.wb = (op < 5'd16) ? 1'b1 : 1'b0;
        endcase
    endtask

    // Offer one op, wait (bounded) for acceptance; acc_cyc holds the accept edge.
    task automatic send(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push = 1);
        beat_t r;
        bit    ok;
        ok = 0;
        in_valid = 1'b1; in_op = op; in_v1 = a; in_v2 = b;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
                acc_cyc = cyc;
                if (push) begin
                    model(op, a, b, r);
                    expq.push_back(r);
                end
            end
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (expq.size() != 0 || out_valid); i++) @(posedge clk);
        #1;
        chk("drain_queue_empty", expq.size(), 0);
    endtask

    // Monitor: pops on every transferred beat, checks hold stability under backpressure.
    beat_t        mon_r;
    logic [W-1:0] held_data;
    logic         held_wb;
    bit           held = 0;
    always @(negedge clk) begin
        if (resetn && out_valid) begin
            if (held) begin
                chk("stable_data", out_data, held_data);
                chk("stable_wb", out_wb, held_wb);
            end
            if (out_ready) begin
                held = 0;
                if (expq.size() == 0) chk("unexpected_beat", 1, 0);
                else begin
                    mon_r = expq.pop_front();
                    chk("out_data", out_data, mon_r.data);
                    chk("out_wb", out_wb, mon_r.wb);
                end
            end else begin
                held = 1; held_data = out_data; held_wb = out_wb;
            end
        end else begin
            held = 0;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    localparam logic [4:0] OPS [24] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd6, 5'd7, 5'd8, 5'd9,
        5'd10, 5'd11, 5'd12, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21,
        5'd22, 5'd23, 5'd4, 5'd13, 5'd25};

    initial begin
        int  n, k, a0;
        bit  bad;
        logic [W-1:0] ra, rb;
        logic [4:0]   rop;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_wb", out_wb, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk) resetn = 1'b1;
        @(negedge clk) chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        send(5'd12, 32'h7FFF_FFFF, 32'h1);
        send(5'd7, 32'h1, 32'hFFFF_FFFF);
        send(5'd6, 32'h1, 32'hFFFF_FFFF);
        send(5'd3, 32'h21, 32'h8000_0000);
        send(5'd21, 0, 0);
        drain();

        // back-to-back simple ops: one accept per cycle
        send(5'd9, 32'hF0, 32'h0F); a0 = acc_cyc;
        send(5'd10, 32'hFF, 32'h0F);
        send(5'd11, 32'h0, 32'h0);
        send(5'd0, 32'h4, 32'h1);
        chk("b2b_accept_span", acc_cyc - a0, 3);
        drain();

        // MULT latency and busy stall
        send(5'd16, -32'sd3, 32'd5);
        n = 0; bad = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
            if (!out_valid && in_ready) bad = 1;
        end
        chk("mult_latency", n, 33);
        chk("in_ready_low_while_busy", bad, 0);
        send(5'd20, 0, 0);
        send(5'd21, 0, 0);
        drain();

        send(5'd18, -32'sd7, 32'd2);      send(5'd20, 0, 0); send(5'd21, 0, 0);
        send(5'd19, 32'd7, 32'd0);        send(5'd20, 0, 0); send(5'd21, 0, 0);
        send(5'd18, 32'h8000_0000, '1);   send(5'd20, 0, 0); send(5'd21, 0, 0);
        send(5'd18, -32'sd9, 32'd0);      send(5'd20, 0, 0); send(5'd21, 0, 0);
        drain();

        // kill mid-DIVU
        send(5'd22, 32'h1234, 0);
        drain();
        send(5'd19, 32'hDEAD_BEEF, 32'h13, 0);
        a0 = acc_cyc;
        repeat (9) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1 kill = 1'b0;
        chk("kill_busy_cleared", busy, 0);
        chk("kill_no_out_valid", out_valid, 0);
        send(5'd20, 0, 0);
        chk("kill_next_accept_cycle", acc_cyc - a0, 11);
        drain();

        // backpressure
        out_ready = 1'b0;
        send(5'd12, 32'h10, 32'h20);
        in_valid = 1'b1; in_op = 5'd14; in_v1 = 32'h5; in_v2 = 32'h9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_out_valid_held", out_valid, 1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        k = cyc;
        send(5'd14, 32'h5, 32'h9);
        chk("bp_accept_on_release", acc_cyc, k + 1);
        drain();

        // reset mid-MULT
        send(5'd22, 32'hAAAA, 0);
        drain();
        send(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) @(posedge clk);
        #1 resetn = 1'b0;
        expq.delete();
        m_hi = '0; m_lo = '0;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        @(negedge clk) resetn = 1'b1;
        @(negedge clk) chk("rst_mid_in_ready", in_ready, 1);
        @(posedge clk); #1;
        send(5'd20, 0, 0);
        send(5'd21, 0, 0);
        drain();

        // randomized traffic with random backpressure
        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            rop = OPS[$urandom_range(0, 23)];
            ra  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = W'($urandom_range(0, 9));
                2: rb = '1;
                default: rb = W'($urandom);
            endcase
            send(rop, ra, rb);
        end
        @(posedge clk);
        rand_ready = 0;
        #2 out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
